// File: rtl/divider_pkg.sv
// Shared widths, state/special-case encodings and helpers for the iterative RV32M divider.
package divider_pkg;

   localparam int DATA_LEN         = 32;
   localparam int CNT_W            = 5;
   localparam int MD_OUT_SEL_WIDTH = 1;

   localparam logic [DATA_LEN-1:0] MIN_INT  = {1'b1, {(DATA_LEN-1){1'b0}}};
   localparam logic [DATA_LEN-1:0] ALL_ONES = {DATA_LEN{1'b1}};
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_DIV0 = 2'd1,
      SP_OVF  = 2'd2
   } div_special_e;

   // Two's-complement negate when en is set.
   function automatic logic [DATA_LEN-1:0] neg_if(input logic [DATA_LEN-1:0] v, input logic en);
      return en ? (~v + {{(DATA_LEN-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface divider_if;
   import divider_pkg::*;

   logic                        start;
   logic                        flush;
   logic [DATA_LEN-1:0]         src1;
   logic [DATA_LEN-1:0]         src2;
   logic                        op_signed;
   logic [MD_OUT_SEL_WIDTH-1:0] md_out_sel;
   logic                        busy;
   logic                        done;
   logic [DATA_LEN-1:0]         result;

   modport master (
      output start, flush, src1, src2, op_signed, md_out_sel,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, src1, src2, op_signed, md_out_sel,
      output busy, done, result
   );
endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit and try subtracting the divisor.
module divider_step
   import divider_pkg::*;
(
   input  logic [DATA_LEN-1:0] rem_i,
   input  logic                dvd_msb_i,
   input  logic [DATA_LEN-1:0] dsr_i,
   output logic [DATA_LEN-1:0] rem_o,
   output logic                q_bit_o
);

   logic [DATA_LEN:0] shifted_s;
   logic [DATA_LEN:0] trial_s;

   // Trial subtraction; the extra top bit is the borrow that says the divisor did not fit.
   always_comb begin
      shifted_s = {rem_i, dvd_msb_i};
      trial_s   = shifted_s - {1'b0, dsr_i};
      if (trial_s[DATA_LEN] == 1'b0) begin
         rem_o   = trial_s[DATA_LEN-1:0];
         q_bit_o = 1'b1;
      end else begin
         rem_o   = shifted_s[DATA_LEN-1:0];
         q_bit_o = 1'b0;
      end
   end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: control FSM, operand prep and sign fix-up.
module divider
   import divider_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   divider_if.slave bus
);

   div_state_e          state_q, state_d;
   div_special_e        special_q, special_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_LEN-1:0] dvd_q, dvd_d;
   logic [DATA_LEN-1:0] rem_q, rem_d;
   logic [DATA_LEN-1:0] dsr_q, dsr_d;
   logic [DATA_LEN-1:0] res_q, res_d;
   logic                sgn_dvd_q, sgn_dvd_d;
   logic                sgn_dsr_q, sgn_dsr_d;
   logic                sel_rem_q, sel_rem_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_LEN-1:0] result_q, result_d;

   logic [DATA_LEN-1:0] step_rem_s;
   logic                step_q_s;
   logic                sgn1_s;
   logic                sgn2_s;
   logic                div0_s;
   logic                ovf_s;

   divider_step u_step (
      .rem_i     (rem_q),
      .dvd_msb_i (dvd_q[DATA_LEN-1]),
      .dsr_i     (dsr_q),
      .rem_o     (step_rem_s),
      .q_bit_o   (step_q_s)
   );

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d   = state_q;
      special_d = special_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dsr_d     = dsr_q;
      res_d     = res_q;
      sgn_dvd_d = sgn_dvd_q;
      sgn_dsr_d = sgn_dsr_q;
      sel_rem_d = sel_rem_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      result_d  = result_q;

      sgn1_s = bus.op_signed & bus.src1[DATA_LEN-1];
      sgn2_s = bus.op_signed & bus.src2[DATA_LEN-1];
      div0_s = (bus.src2 == {DATA_LEN{1'b0}});
      ovf_s  = bus.op_signed & (bus.src1 == MIN_INT) & (bus.src2 == ALL_ONES);

      case (state_q)
         ST_IDLE: begin
            // done_q high means the FSM only just left DONE; that start belongs to the done cycle.
            if (bus.start && !done_q) begin
               sel_rem_d = bus.md_out_sel[0];
               sgn_dvd_d = sgn1_s;
               sgn_dsr_d = sgn2_s;
               dvd_d     = neg_if(bus.src1, sgn1_s);
               dsr_d     = neg_if(bus.src2, sgn2_s);
               rem_d     = {DATA_LEN{1'b0}};
               cnt_d     = {CNT_W{1'b0}};
               if (div0_s) begin
                  special_d = SP_DIV0;
                  dvd_d     = bus.src1;
                  state_d   = ST_DONE;
               end else if (ovf_s) begin
                  special_d = SP_OVF;
                  state_d   = ST_DONE;
               end else begin
                  special_d = SP_NONE;
                  state_d   = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            busy_d = 1'b1;
            rem_d  = step_rem_s;
            dvd_d  = {dvd_q[DATA_LEN-2:0], step_q_s};
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX: begin
            busy_d  = 1'b1;
            res_d   = sel_rem_q ? neg_if(rem_q, sgn_dvd_q)
                                : neg_if(dvd_q, sgn_dvd_q ^ sgn_dsr_q);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            case (special_q)
               SP_DIV0: result_d = sel_rem_q ? dvd_q : ALL_ONES;
               SP_OVF:  result_d = sel_rem_q ? {DATA_LEN{1'b0}} : MIN_INT;
               default: result_d = res_q;
            endcase
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush wins over everything: abandon the operation silently.
      state_d  = bus.flush ? ST_IDLE  : state_d;
      busy_d   = bus.flush ? 1'b0     : busy_d;
      done_d   = bus.flush ? 1'b0     : done_d;
      result_d = bus.flush ? result_q : result_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         special_q <= SP_NONE;
         cnt_q     <= {CNT_W{1'b0}};
         dvd_q     <= {DATA_LEN{1'b0}};
         rem_q     <= {DATA_LEN{1'b0}};
         dsr_q     <= {DATA_LEN{1'b0}};
         res_q     <= {DATA_LEN{1'b0}};
         sgn_dvd_q <= 1'b0;
         sgn_dsr_q <= 1'b0;
         sel_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= {DATA_LEN{1'b0}};
      end else begin
         state_q   <= state_d;
         special_q <= special_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         dsr_q     <= dsr_d;
         res_q     <= res_d;
         sgn_dvd_q <= sgn_dvd_d;
         sgn_dsr_q <= sgn_dsr_d;
         sel_rem_q <= sel_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- It is the inverse-operation partner of the combinational multiplier in the execute stage. It shares the `DATA_LEN` operand width and the `md_out_sel` encoding.
- It accepts one operation per start pulse, runs for a fixed number of cycles, then returns the quotient or remainder with a one-cycle done pulse.
- The pipeline stalls on busy.

Parameters:
- DATA_LEN, 32 (from defines.v): operand and result width.
- CNT_W, 5: iteration counter width, equal to log2(DATA_LEN).

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new division. Sampled only in IDLE.
- flush  in  1  abort the operation in flight (pipeline flush).
- src1  in  DATA_LEN  dividend.
- src2  in  DATA_LEN  divisor.
- op_signed  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- md_out_sel  in  MD_OUT_SEL_WIDTH  bit[0]: 0 = quotient, 1 = remainder. Latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  DATA_LEN  selected quotient/remainder. Held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all datapath registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op_signed and md_out_sel[0].
  - Operand signs are captured as: dividend sign = op_signed & src1[MSB]; divisor sign = op_signed & src2[MSB].
  - Absolute values are loaded. Remainder register is cleared; counter is cleared.
  - Divide-by-zero (src2==0): go directly to DONE.
  - Signed overflow (op_signed, src1=0x80000000, src2=0xFFFFFFFF): go directly to DONE.
  - Otherwise go to CALC.
- CALC:
  - One quotient bit per cycle: shift {rem,dvd} left by 1; trial = rem - divisor (DATA_LEN+1 bits).
  - If trial is non-negative, rem=trial and q bit=1; otherwise q bit=0.
  - After DATA_LEN iterations (counter==DATA_LEN-1), go to FIX.
- FIX:
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend sign is 1.
  - Register result per the latched select, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
  - Special-case results are written in this state:
    - Divide-by-zero: quotient=all ones; remainder=src1 unmodified.
    - Overflow: quotient=0x80000000; remainder=0.
- Latency, counting the accepting edge as E0:
  - Normal operation: done is high in the cycle after edge E(DATA_LEN+2), i.e. 34 cycles at DATA_LEN=32.
  - Special cases: done is high after edge E1.
- busy is high in CALC and FIX only.
- start while not IDLE is ignored. No queuing.
- start in the same cycle as done (state DONE) is ignored. The requester must re-assert start in IDLE.
- flush:
  - In any state, flush forces IDLE at the next edge. done is not asserted and result keeps its previous value.
  - flush takes priority over start in the same cycle.
- The unsigned 0/0 case follows the divide-by-zero rule.
- Reset asserted mid-operation immediately returns the block to reset values.

Decomposition:
- DATA_LEN, MD_OUT_SEL_WIDTH and the state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3) live in defines.v.
- A combinational sub-module div_step is natural. It takes rem, the dividend MSB and the divisor, and produces the next rem and the quotient bit.
- The control FSM and sign fix-up stay in divider.

Test Plan:
- Unsigned: DIVU 100/7, then REMU 100/7 → result 14, then 2. done is high exactly 34 cycles after start; busy is high for cycles 1..33.
- Signed: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIV 7/-2 → -3; REM 7/-2 → 1.
- Divide-by-zero: DIVU 0x1234/0 → 0xFFFFFFFF. REM 0x80000005/0 → 0x80000005. done is high after 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. done is high after 1 cycle.
- Flush: start DIVU 50/5, flush at cycle 10, then start DIVU 9/3. No done appears for the first operation; result=3 after 34 cycles. A start pulsed while busy has no effect.
- Reset: assert rst_n=0 asynchronously mid-CALC (between clock edges). busy, done and result go to 0 immediately; IDLE is entered; the next operation computes correctly.
